fpu_issue: RTL

Issue and writeback sequencer placed between the core's execute stage and the FPU. It buffers FP requests, drives the FPU's `ctl`/`x1`/`x2`/`en` inputs with a one-cycle `en` pulse, and holds the operands stable until the FPU pulses `ready`. It then returns the result to the core with a tag over a valid/ready handshake. It also rejects illegal opcodes and recovers from a hung FPU operation through a timeout.

---
 rtl/fpu_issue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fpu_issue.sv
`timescale 1ns/1ps
// Issue/writeback sequencer between the execute stage and the FPU: queues FP
// requests, pulses fpu_en once per op, holds operands until fpu_ready, returns tagged results.
module fpu_issue #(
  parameter int TAG_W   = 5,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_ctl,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [4:0]       fpu_ctl,
  output logic [31:0]      fpu_x1,
  output logic [31:0]      fpu_x2,
  output logic             fpu_en,
  input  logic             fpu_ready,
  input  logic [31:0]      fpu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_int,
  output logic             res_err,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  logic [4:0]       ctlMem_q [DEPTH];
  logic [31:0]      x1Mem_q  [DEPTH];
  logic [31:0]      x2Mem_q  [DEPTH];
  logic [TAG_W-1:0] tagMem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;

  state_t           state_q;
  logic [CW-1:0]    timeoutCnt_q;
  logic             illegal_q;
  logic [4:0]       fpuCtl_q;
  logic [31:0]      fpuX1_q, fpuX2_q;
  logic             fpuEn_q;
  logic             resValid_q;
  logic [31:0]      resData_q;
  logic [TAG_W-1:0] resTag_q;
  logic             resInt_q;
  logic             resErr_q;

  logic fifoEmpty, fifoFull, push, pop;
  logic [4:0] headCtl;

  function automatic logic isIntOp(input logic [4:0] ctl);
    case (ctl)
      5'd6, 5'd9, 5'd10, 5'd13, 5'd16, 5'd17, 5'd18: isIntOp = 1'b1;
      default:                                       isIntOp = 1'b0;
    endcase
  endfunction

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign push      = req_valid && !fifoFull;
  assign pop       = (state_q == IDLE) && !fifoEmpty;
  assign headCtl   = ctlMem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) wrPtr_d = wrPtr_q + (AW+1)'(1);
    if (pop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      if (push) begin
        ctlMem_q[wrPtr_q[AW-1:0]] <= req_ctl;
        x1Mem_q[wrPtr_q[AW-1:0]]  <= req_x1;
        x2Mem_q[wrPtr_q[AW-1:0]]  <= req_x2;
        tagMem_q[wrPtr_q[AW-1:0]] <= req_tag;
      end
    end
  end

  // Illegal opcodes spend one cycle in ISSUE with fpu_en held low so their
  // error result appears two edges after acceptance, without touching the FPU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timeoutCnt_q <= '0;
      illegal_q    <= 1'b0;
      fpuCtl_q     <= '0;
      fpuX1_q      <= '0;
      fpuX2_q      <= '0;
      fpuEn_q      <= 1'b0;
      resValid_q   <= 1'b0;
      resData_q    <= '0;
      resTag_q     <= '0;
      resInt_q     <= 1'b0;
      resErr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            fpuCtl_q <= headCtl;
            fpuX1_q  <= x1Mem_q[rdPtr_q[AW-1:0]];
            fpuX2_q  <= x2Mem_q[rdPtr_q[AW-1:0]];
            resTag_q <= tagMem_q[rdPtr_q[AW-1:0]];
            resInt_q <= isIntOp(headCtl);
            if (headCtl <= 5'd20) begin
              fpuEn_q   <= 1'b1;
              illegal_q <= 1'b0;
            end else begin
              resData_q <= '0;
              resErr_q  <= 1'b1;
              illegal_q <= 1'b1;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          fpuEn_q      <= 1'b0;
          timeoutCnt_q <= '0;
          if (illegal_q) begin
            resValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (fpu_ready) begin
            resData_q  <= fpu_y;
            resErr_q   <= 1'b0;
            resValid_q <= 1'b1;
            state_q    <= DONE;
          end else if (timeoutCnt_q == CW'(TIMEOUT)) begin
            resData_q  <= '0;
            resErr_q   <= 1'b1;
            resValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + CW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            resValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = !fifoFull;
  assign fpu_ctl   = fpuCtl_q;
  assign fpu_x1    = fpuX1_q;
  assign fpu_x2    = fpuX2_q;
  assign fpu_en    = fpuEn_q;
  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_tag   = resTag_q;
  assign res_int   = resInt_q;
  assign res_err   = resErr_q;
  assign busy      = !fifoEmpty || (state_q != IDLE);

endmodule
